load_align_unit: RTL and testbench
==================================

// Module: load_align_unit
// PURPOSE
//  Memory-stage load engine. Takes one load request, issues a word-aligned
//  read to the data port, waits for mem_resp, then extracts and extends the
//  byte/half/word. Result drives the load-data inputs of the 8:1 writeback
//  select mux. One outstanding load; multi-cycle memory latency tolerated.
// PARAMETERS
//  MAX_WAIT  64  cycles in WAIT without mem_resp before timeout error (>=2)
//  CNT_W     7   width of wait counter; must hold MAX_WAIT
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  req_valid     in   1   load request present
//  req_ready     out  1   unit can accept request (IDLE only)
//  req_funct3    in   3   RV32I load funct3
//  req_addr      in   32  byte address
//  flush         in   1   kill current/incoming load (pipeline squash)
//  mem_read      out  1   data-port read strobe, held until mem_resp
//  mem_address   out  32  {req_addr[31:2],2'b00}
//  mem_rdata     in   32  read data, valid with mem_resp
//  mem_resp      in   1   read complete
//  load_valid    out  1   one-cycle pulse: load_data/load_err valid
//  load_data     out  32  extended load result
//  load_err      out  1   misaligned, illegal funct3 or timeout (with load_valid)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, mem_read=0, mem_address=0, load_valid=0,
//   load_data=0, load_err=0, counter=0; req_ready forced 0 while rst=1.
//  States: IDLE, WAIT, DONE, DRAIN. All outputs registered except req_ready.
//  IDLE: req_ready=1. Accept on req_valid && !flush.
//   - Illegal: funct3 in {011,110,111}; LH/LHU with addr[0]=1; LW with
//     addr[1:0]!=0 -> DONE with load_err=1, load_data=0; no memory access.
//   - Legal: latch funct3, addr[1:0]; mem_read=1, mem_address set next edge;
//     counter=0; -> WAIT.
//   - req_valid && flush: request dropped, stay IDLE.
//  WAIT: req_ready=0; mem_read, mem_address held; counter++ per cycle.
//   - mem_resp: mem_read=0; load_data=extend(mem_rdata); -> DONE, err=0.
//   - flush (no mem_resp): -> DRAIN (read must still complete).
//   - flush && mem_resp same cycle: drop result, mem_read=0, -> IDLE.
//   - counter==MAX_WAIT-1 && !mem_resp: mem_read=0, load_err=1, load_data=0,
//     -> DONE. mem_resp wins over timeout in same cycle.
//  DRAIN: mem_read held until mem_resp, data discarded, no load_valid; ->IDLE.
//  DONE: load_valid=1 exactly one cycle; -> IDLE. load_data held after pulse
//   until next completion. flush in DONE does not suppress the pulse.
//  Extract (s=addr[1:0]):
//   000 LB : sext8(rdata[8*s+:8])      100 LBU: zext8(rdata[8*s+:8])
//   001 LH : sext16(rdata[16*s[1]+:16]) 101 LHU: zext16(rdata[16*s[1]+:16])
//   010 LW : rdata
//  mem_resp outside WAIT/DRAIN ignored. Min latency req accept -> load_valid:
//   3 edges with mem_resp on first WAIT cycle.
// TESTING
//  LB addr=0x1003, rdata=0x80AB_CDEF, resp after 1 cyc -> load_data=0xFFFFFF80.
//  LHU addr=0x2002, rdata=0x8001_1234 -> load_data=0x00008001, load_err=0.
//  LW addr=0x3001 -> no mem_read, load_valid pulse, load_err=1, data=0.
//  LW, no mem_resp for MAX_WAIT cycles -> mem_read drops, load_err=1 pulse.
//  flush in WAIT then mem_resp 5 cyc later -> mem_read held, no load_valid,
//   req_ready=1 cycle after resp.
//  rst asserted mid-WAIT -> all outputs 0 immediately, req_ready=0, IDLE after.

Source files
------------

// File: rtl/load_align_unit.sv
// Memory-stage load engine: issues one word-aligned read, waits for the response,
// then extracts and sign/zero-extends the addressed byte, half or word.
module load_align_unit #(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        load_err
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic [31:0]       mem_address_q, mem_address_d;
  logic              load_valid_q, load_valid_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_err_q, load_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        offs_q, offs_d;

  logic              req_illegal;
  logic              timeout;
  logic [31:0]       extended;

  // Unsupported funct3 or an address not aligned to the access size.
  function automatic logic is_illegal(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    unique case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = a[0];
      3'b010:         bad = (a != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0]  f3,
                                         input logic [1:0]  s,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (s)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = s[1] ? rd[31:16] : rd[15:0];
    unique case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      3'b010:  r = rd;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign req_illegal = is_illegal(req_funct3, req_addr[1:0]);
  assign timeout     = (cnt_q == CNT_W'(MAX_WAIT - 1));
  assign extended    = extend(funct3_q, offs_q, mem_rdata);

  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    load_valid_d  = 1'b0;
    load_data_d   = load_data_q;
    load_err_d    = load_err_q;
    cnt_d         = cnt_q;
    funct3_d      = funct3_q;
    offs_d        = offs_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          if (req_illegal) begin
            load_err_d  = 1'b1;
            load_data_d = 32'd0;
            state_d     = StDone;
          end else begin
            funct3_d      = req_funct3;
            offs_d        = req_addr[1:0];
            mem_read_d    = 1'b1;
            mem_address_d = {req_addr[31:2], 2'b00};
            cnt_d         = '0;
            state_d       = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_resp) begin
          mem_read_d = 1'b0;
          if (flush) begin
            state_d = StIdle;
          end else begin
            load_data_d = extended;
            load_err_d  = 1'b0;
            state_d     = StDone;
          end
        end else if (flush) begin
          // A squashed read is still in flight; wait it out without reporting.
          state_d = StDrain;
        end else if (timeout) begin
          mem_read_d  = 1'b0;
          load_err_d  = 1'b1;
          load_data_d = 32'd0;
          state_d     = StDone;
        end
      end
      StDrain: begin
        if (mem_resp) begin
          mem_read_d = 1'b0;
          state_d    = StIdle;
        end
      end
      StDone: begin
        load_valid_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      mem_read_q    <= 1'b0;
      mem_address_q <= 32'd0;
      load_valid_q  <= 1'b0;
      load_data_q   <= 32'd0;
      load_err_q    <= 1'b0;
      cnt_q         <= '0;
      funct3_q      <= 3'd0;
      offs_q        <= 2'd0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      load_valid_q  <= load_valid_d;
      load_data_q   <= load_data_d;
      load_err_q    <= load_err_d;
      cnt_q         <= cnt_d;
      funct3_q      <= funct3_d;
      offs_q        <= offs_d;
    end
  end

  assign req_ready   = (state_q == StIdle) && !rst;
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;
  assign load_valid  = load_valid_q;
  assign load_data   = load_data_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed-vector bench for load_align_unit with hand-computed expected results.
module tb_load_align_unit;

  localparam int unsigned MaxWait = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic        flush;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_err;

  int unsigned n_checks;
  int unsigned n_pass;

  load_align_unit #(
    .MAX_WAIT(MaxWait),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .flush      (flush),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Legal load with `delay` WAIT cycles before mem_resp.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int delay, input logic [31:0] exp);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_addr   = addr;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check({tag, " mem_read"}, 32'(mem_read), 32'd1);
    check({tag, " mem_address"}, mem_address, {addr[31:2], 2'b00});
    check({tag, " ready busy"}, 32'(req_ready), 32'd0);
    repeat (delay) step();
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    step();
    mem_resp = 1'b0;
    check({tag, " read drop"}, 32'(mem_read), 32'd0);
    check({tag, " no early valid"}, 32'(load_valid), 32'd0);
    step();
    check({tag, " valid"}, 32'(load_valid), 32'd1);
    check({tag, " data"}, load_data, exp);
    check({tag, " err"}, 32'(load_err), 32'd0);
    step();
    check({tag, " pulse end"}, 32'(load_valid), 32'd0);
  endtask

  // Request rejected up front: no memory access, error pulse.
  task automatic do_bad(input string tag, input logic [2:0] f3, input logic [31:0] addr);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_addr   = addr;
    step();
    req_valid = 1'b0;
    check({tag, " no read"}, 32'(mem_read), 32'd0);
    step();
    check({tag, " no read 2"}, 32'(mem_read), 32'd0);
    check({tag, " valid"}, 32'(load_valid), 32'd1);
    check({tag, " err"}, 32'(load_err), 32'd1);
    check({tag, " data"}, load_data, 32'd0);
    step();
    check({tag, " pulse end"}, 32'(load_valid), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    flush      = 1'b0;
    mem_rdata  = 32'd0;
    mem_resp   = 1'b0;

    #12;
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst mem_read", 32'(mem_read), 32'd0);
    check("rst address", mem_address, 32'd0);
    check("rst valid", 32'(load_valid), 32'd0);
    check("rst data", load_data, 32'd0);
    check("rst err", 32'(load_err), 32'd0);
    rst = 1'b0;
    step();
    check("idle ready", 32'(req_ready), 32'd1);

    do_load("lb3",  3'b000, 32'h0000_1003, 32'h80AB_CDEF, 1, 32'hFFFF_FF80);
    do_load("lhu2", 3'b101, 32'h0000_2002, 32'h8001_1234, 2, 32'h0000_8001);
    do_load("lb1",  3'b000, 32'h0000_1001, 32'h80AB_CDEF, 0, 32'hFFFF_FFCD);
    do_load("lbu2", 3'b100, 32'h0000_1002, 32'h80AB_CDEF, 0, 32'h0000_00AB);
    do_load("lbu0", 3'b100, 32'h0000_1000, 32'h80AB_CDEF, 3, 32'h0000_00EF);
    do_load("lh0",  3'b001, 32'h0000_2000, 32'h1234_8765, 0, 32'hFFFF_8765);
    do_load("lh2",  3'b001, 32'h0000_2002, 32'h1234_8765, 1, 32'h0000_1234);
    do_load("lw",   3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF);

    do_bad("lw mis", 3'b010, 32'h0000_3001);
    do_bad("lh mis", 3'b001, 32'h0000_2003);
    do_bad("f3 011", 3'b011, 32'h0000_3000);
    do_bad("f3 110", 3'b110, 32'h0000_3000);

    // Timeout: the MaxWait-th WAIT cycle without a response aborts the read.
    req_valid  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_4000;
    step();
    req_valid = 1'b0;
    repeat (MaxWait - 1) step();
    check("to held", 32'(mem_read), 32'd1);
    step();
    check("to drop", 32'(mem_read), 32'd0);
    check("to no early valid", 32'(load_valid), 32'd0);
    step();
    check("to valid", 32'(load_valid), 32'd1);
    check("to err", 32'(load_err), 32'd1);
    check("to data", load_data, 32'd0);
    step();

    // Flush in WAIT, response 5 cycles later: result is discarded.
    do_load("pre", 3'b010, 32'h0000_6000, 32'h1111_2222, 0, 32'h1111_2222);
    req_valid = 1'b1;
    req_addr  = 32'h0000_5000;
    step();
    req_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drain held", 32'(mem_read), 32'd1);
      check("drain no valid", 32'(load_valid), 32'd0);
      check("drain busy", 32'(req_ready), 32'd0);
      step();
    end
    mem_resp  = 1'b1;
    mem_rdata = 32'h5555_5555;
    step();
    mem_resp = 1'b0;
    check("drain drop", 32'(mem_read), 32'd0);
    check("drain ready", 32'(req_ready), 32'd1);
    step();
    check("drain no valid late", 32'(load_valid), 32'd0);
    check("drain data kept", load_data, 32'h1111_2222);

    // Request with flush in IDLE is dropped.
    req_valid = 1'b1;
    flush     = 1'b1;
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    check("idle flush ready", 32'(req_ready), 32'd1);
    check("idle flush no read", 32'(mem_read), 32'd0);

    // Stray response in IDLE is ignored.
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    step();
    check("stray no valid", 32'(load_valid), 32'd0);

    // Flush and response together in WAIT.
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    flush     = 1'b1;
    mem_resp  = 1'b1;
    step();
    flush    = 1'b0;
    mem_resp = 1'b0;
    check("fr drop", 32'(mem_read), 32'd0);
    check("fr ready", 32'(req_ready), 32'd1);
    step();
    check("fr no valid", 32'(load_valid), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    req_valid  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h0000_7001;
    step();
    req_valid = 1'b0;
    check("pre-rst read", 32'(mem_read), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst mem_read", 32'(mem_read), 32'd0);
    check("arst address", mem_address, 32'd0);
    check("arst data", load_data, 32'd0);
    check("arst ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post-rst ready", 32'(req_ready), 32'd1);
    check("post-rst valid", 32'(load_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
